// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_DATA,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } fetch_state_t;

  localparam int          INSTRUCTION_BYTES = 4;
  localparam logic [31:0] RESET_INSTRUCTION = 32'h00000013;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting for a memory response; expired_o flags the cycle
// on which the count reaches TIMEOUT_CYCLES.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 1'b1;
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch controller: requests the word at the current PC, buffers it for the
// decoder and steers the PC write port (PC+4 or branch redirect).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcOfInstruction,
  input  logic        programCounterMisaligned,
  output logic [31:0] programCounterInput,
  output logic        programCounterWriteEnable,
  output logic [31:0] memAddress,
  output logic        memReadRequest,
  input  logic        memReadReady,
  input  logic        memReadDataValid,
  input  logic [31:0] memReadData,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic [31:0] instructionOut,
  output logic [31:0] instructionPc,
  output logic        instructionValid,
  input  logic        instructionReady,
  output logic        fetchFault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic         cnt_clr, cnt_en, cnt_expired;

  fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (cnt_clr),
    .enable_i  (cnt_en),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d                   = state_q;
    instr_d                   = instr_q;
    ipc_d                     = ipc_q;
    valid_d                   = valid_q;
    fault_d                   = fault_q;
    memReadRequest            = 1'b0;
    memAddress                = '0;
    programCounterWriteEnable = 1'b0;
    programCounterInput       = '0;
    cnt_clr                   = 1'b1;
    cnt_en                    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQUEST;
      S_REQUEST: begin
        memAddress = pcOfInstruction;
        if (redirectValid) begin
          programCounterWriteEnable = 1'b1;
          programCounterInput       = redirectTarget;
        end else if (programCounterMisaligned) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          memReadRequest = 1'b1;
          if (memReadReady) begin
            ipc_d   = pcOfInstruction;
            state_d = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        cnt_clr = 1'b0;
        if (memReadDataValid) begin
          // A redirect in the same cycle as the data makes the word stale.
          if (redirectValid) begin
            programCounterWriteEnable = 1'b1;
            programCounterInput       = redirectTarget;
            state_d                   = S_REQUEST;
          end else begin
            instr_d = memReadData;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirectValid) begin
          programCounterWriteEnable = 1'b1;
          programCounterInput       = redirectTarget;
          cnt_clr                   = 1'b1;
          state_d                   = S_DRAIN;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirectValid) begin
          programCounterWriteEnable = 1'b1;
          programCounterInput       = redirectTarget;
          valid_d                   = 1'b0;
          state_d                   = S_REQUEST;
        end else if (instructionReady) begin
          programCounterWriteEnable = 1'b1;
          programCounterInput       = ipc_q + 32'(INSTRUCTION_BYTES);
          valid_d                   = 1'b0;
          state_d                   = S_REQUEST;
        end
      end
      S_DRAIN: begin
        cnt_clr = 1'b0;
        if (redirectValid) begin
          programCounterWriteEnable = 1'b1;
          programCounterInput       = redirectTarget;
        end
        if (memReadDataValid) begin
          state_d = S_REQUEST;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign instructionOut   = instr_q;
  assign instructionPc    = ipc_q;
  assign instructionValid = valid_q;
  assign fetchFault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus random checks of instruction_fetch_unit against a
// transaction-level model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pcOfInstruction;
  logic        programCounterMisaligned;
  logic [31:0] programCounterInput;
  logic        programCounterWriteEnable;
  logic [31:0] memAddress;
  logic        memReadRequest;
  logic        memReadReady;
  logic        memReadDataValid;
  logic [31:0] memReadData;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic [31:0] instructionOut;
  logic [31:0] instructionPc;
  logic        instructionValid;
  logic        instructionReady;
  logic        fetchFault;

  instruction_fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .pcOfInstruction           (pcOfInstruction),
    .programCounterMisaligned  (programCounterMisaligned),
    .programCounterInput       (programCounterInput),
    .programCounterWriteEnable (programCounterWriteEnable),
    .memAddress                (memAddress),
    .memReadRequest            (memReadRequest),
    .memReadReady              (memReadReady),
    .memReadDataValid          (memReadDataValid),
    .memReadData               (memReadData),
    .redirectValid             (redirectValid),
    .redirectTarget            (redirectTarget),
    .instructionOut            (instructionOut),
    .instructionPc             (instructionPc),
    .instructionValid          (instructionValid),
    .instructionReady          (instructionReady),
    .fetchFault                (fetchFault)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // environment: PC register and a single-outstanding memory
  logic [31:0] tb_pc;
  logic        mem_pending;
  logic        s_we, s_acc, s_dv;
  logic [31:0] s_pcin;

  // reference model: what the fetcher currently holds / waits for
  logic        m_boot, m_fault, m_have, m_busy, m_drop;
  int          m_wait;
  logic [31:0] m_instr, m_ipc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rdy, input logic dv, input logic [31:0] rd,
                     input logic rv, input logic [31:0] tg, input logic ir);
    logic        e_req, e_we;
    logic [31:0] e_addr, e_pcin, e_out, e_ipc;
    logic        e_valid, e_fault;
    memReadReady     = rdy;
    memReadDataValid = dv;
    memReadData      = rd;
    redirectValid    = rv;
    redirectTarget   = tg;
    instructionReady = ir;
    pcOfInstruction  = tb_pc;
    programCounterMisaligned = |tb_pc[1:0];
    #1;
    e_req = 0; e_we = 0; e_addr = 0; e_pcin = 0;
    e_valid = m_have; e_out = m_instr; e_ipc = m_ipc; e_fault = m_fault;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_fault) begin
    end else if (m_have) begin
      if (rv)      begin e_we = 1; e_pcin = tg;          m_have = 0; end
      else if (ir) begin e_we = 1; e_pcin = m_ipc + 4;   m_have = 0; end
    end else if (m_busy) begin
      if (rv) begin e_we = 1; e_pcin = tg; end
      if (dv) begin
        if (!m_drop && !rv) begin m_have = 1; m_instr = rd; end
        m_busy = 0; m_drop = 0;
      end else if (rv && !m_drop) begin
        m_drop = 1; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TO) m_fault = 1;
      end
    end else begin
      e_addr = tb_pc;
      if (rv)                 begin e_we = 1; e_pcin = tg; end
      else if (|tb_pc[1:0])   m_fault = 1;
      else begin
        e_req = 1;
        if (rdy) begin m_busy = 1; m_drop = 0; m_wait = 0; m_ipc = tb_pc; end
      end
    end
    chk("memReadRequest", memReadRequest, e_req);
    chk("memAddress", memAddress, e_addr);
    chk("pcWriteEnable", programCounterWriteEnable, e_we);
    chk("pcInput", programCounterInput, e_pcin);
    chk("instructionValid", instructionValid, e_valid);
    chk("instructionOut", instructionOut, e_out);
    chk("instructionPc", instructionPc, e_ipc);
    chk("fetchFault", fetchFault, e_fault);
    s_we = programCounterWriteEnable; s_pcin = programCounterInput;
    s_acc = memReadRequest && rdy; s_dv = dv;
  endtask

  task automatic tick();
    @(posedge clock);
    if (s_we)  tb_pc = s_pcin;
    if (s_dv)  mem_pending = 0;
    if (s_acc) mem_pending = 1;
    @(negedge clock);
  endtask

  task automatic cyc(input logic rdy, input logic dv, input logic [31:0] rd,
                     input logic rv, input logic [31:0] tg, input logic ir);
    drv(rdy, dv, rd, rv, tg, ir);
    tick();
  endtask

  task automatic do_reset();
    reset = 0;
    memReadReady = 0; memReadDataValid = 0; memReadData = 0;
    redirectValid = 0; redirectTarget = 0; instructionReady = 0;
    pcOfInstruction = 0; programCounterMisaligned = 0;
    #1;
    chk("rst memReadRequest", memReadRequest, 0);
    chk("rst memAddress", memAddress, 0);
    chk("rst pcWriteEnable", programCounterWriteEnable, 0);
    chk("rst pcInput", programCounterInput, 0);
    chk("rst instructionValid", instructionValid, 0);
    chk("rst instructionOut", instructionOut, 0);
    chk("rst instructionPc", instructionPc, 0);
    chk("rst fetchFault", fetchFault, 0);
    m_boot = 1; m_fault = 0; m_have = 0; m_busy = 0; m_drop = 0; m_wait = 0;
    m_instr = 0; m_ipc = 0; tb_pc = 0; mem_pending = 0;
    s_we = 0; s_acc = 0; s_dv = 0; s_pcin = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    logic [31:0] r;
    logic        rdy, dv, rv, ir;
    logic [31:0] tg;
    reset = 0;
    @(negedge clock);
    do_reset();

    // basic fetch at 0
    cyc(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    chk("first request addr", memAddress, 32'h0);
    tick();
    cyc(0, 1, 32'h00500093, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    chk("first instr", instructionOut, 32'h00500093);
    chk("first pc write", programCounterInput, 32'h4);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("second request addr", memAddress, 32'h4);
    chk("second request", memReadRequest, 1);
    tick();

    // decoder stalls for 5 cycles
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h00a00113, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drv(1, 0, 0, 0, 0, 0);
      chk("stall valid", instructionValid, 1);
      chk("stall no write", programCounterWriteEnable, 0);
      tick();
    end
    cyc(0, 0, 0, 0, 0, 1);

    // redirect while waiting for data at 0x8
    cyc(1, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 32'h100, 0);
    chk("redirect write", programCounterInput, 32'h100);
    tick();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hdeadbeef, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("after drain addr", memAddress, 32'h100);
    chk("after drain no valid", instructionValid, 0);
    tick();

    // redirect and consume in the same HOLD cycle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h12345678, 0, 0, 0);
    drv(0, 0, 0, 1, 32'h200, 1);
    chk("hold redirect wins", programCounterInput, 32'h200);
    tick();

    // PC wrap at 0xFFFFFFFC
    cyc(0, 0, 0, 1, 32'hFFFFFFFC, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h00000013, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    chk("pc wrap", programCounterInput, 32'h0);
    tick();

    // memory never answers
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < TO; k++) begin
      drv(0, 0, 0, 0, 0, 0);
      chk("timeout not yet", fetchFault, 0);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("timeout fault", fetchFault, 1);
    tick();
    do_reset();

    // misaligned PC
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0000000A, 0);
    drv(1, 0, 0, 0, 0, 0);
    chk("misaligned no request", memReadRequest, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1, 0, 0, 1, 32'h40, 1);
      chk("fault sticky", fetchFault, 1);
      chk("fault no write", programCounterWriteEnable, 0);
      tick();
    end
    do_reset();
    chk("fault cleared", fetchFault, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom % 4) != 0;
      dv  = mem_pending && (($urandom % 3) != 0);
      rv  = ($urandom % 10) == 0;
      r   = $urandom;
      tg  = (($urandom % 25) == 0) ? r : (r & 32'hFFFFFFFC);
      ir  = ($urandom % 3) != 0;
      cyc(rdy, dv, $urandom, rv, tg, ir);
      if (m_fault && (($urandom % 4) == 0)) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch controller between the program counter register and instruction memory. Reads the current PC and issues a read-request handshake to memory. Buffers the returned word and presents it to the decoder with a valid/ready handshake. Drives the PC write port with PC+4 on consumption, or with a redirect target from the branch unit, discarding any in-flight fetch on redirect.

## Interface
- TIMEOUT_CYCLES, 16, max cycles in WAIT_DATA/DRAIN without memReadDataValid before fault; legal range 1..255
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pcOfInstruction  in  32  current PC from the PC register
- programCounterMisaligned  in  1  PC[1:0] != 0
- programCounterInput  out  32  next PC value
- programCounterWriteEnable  out  1  PC register loads programCounterInput at next edge
- memAddress  out  32  fetch address; pcOfInstruction in REQUEST, else 0
- memReadRequest  out  1  fetch request
- memReadReady  in  1  memory accepts request this cycle
- memReadDataValid  in  1  memReadData valid this cycle
- memReadData  in  32  returned instruction word
- redirectValid  in  1  branch/jump taken this cycle
- redirectTarget  in  32  new PC on redirect
- instructionOut  out  32  buffered instruction
- instructionPc  out  32  PC of instructionOut
- instructionValid  out  1  instructionOut/instructionPc valid
- instructionReady  in  1  decoder consumes this cycle
- fetchFault  out  1  sticky fault: misaligned PC or memory timeout

## Operation
- States: IDLE, REQUEST, WAIT_DATA, HOLD, DRAIN, FAULT.
- Reset: state IDLE. All outputs 0. Buffers and counter cleared.
- IDLE: unconditionally goes to REQUEST on the next edge.
- REQUEST, priority order:
  - redirectValid: memReadRequest forced 0; PC written with redirectTarget; stay REQUEST.
  - programCounterMisaligned: go to FAULT with no request.
  - Otherwise memReadRequest=1. On memReadReady, capture pcOfInstruction into instructionPc buffer and go to WAIT_DATA with counter=0.
- WAIT_DATA:
  - memReadDataValid: capture memReadData and go to HOLD.
  - redirectValid without data: PC written with redirectTarget; go to DRAIN.
  - redirectValid with data in the same cycle: data discarded; go to REQUEST.
  - Otherwise counter increments. On reaching TIMEOUT_CYCLES, go to FAULT.
- HOLD: instructionValid=1; buffers stable.
  - instructionReady without redirect: PC written with instructionPc+4 (mod 2^32, wraps at 0xFFFFFFFC); go to REQUEST.
  - redirectValid, with or without instructionReady: PC written with redirectTarget; go to REQUEST. If ready was high, the instruction counts as delivered.
- DRAIN: waits for the orphaned response and discards it.
  - Further redirects rewrite the PC and stay in DRAIN.
  - memReadDataValid: go to REQUEST.
  - Timeout rule as in WAIT_DATA.
- FAULT: fetchFault=1. All request, valid and write-enable outputs 0. Redirects ignored. Exits only on reset.
- programCounterWriteEnable is asserted for exactly one cycle per PC update. It is never asserted in IDLE or FAULT.

## Timing
- Outputs memReadRequest, memAddress and programCounterWriteEnable/Input are combinational from state and inputs.
- Outputs instructionOut, instructionPc, instructionValid and fetchFault are registered.
- The PC update is visible on pcOfInstruction in the cycle after the write. REQUEST always begins in that cycle, so it uses the new PC.
- Minimum fetch: REQUEST with ready (cycle 0), data valid (cycle 1), HOLD with valid (cycle 2), ready (cycle 2). Next REQUEST is cycle 3, for a throughput of 1 instruction per 3 cycles.
- Asynchronous reset mid-operation: abandons all state immediately, with no drain. Memory-side cleanup is the system's responsibility.

## Structure
- Shared package fetch_pkg holds:
  - enum fetch_state_t (the six states)
  - INSTRUCTION_BYTES = 4
  - RESET_INSTRUCTION = 32'h00000013 (NOP) for future bubble use
- One sub-module: fetch_timeout_counter.
  - Clear/enable/expired outputs.
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Shared by WAIT_DATA and DRAIN.

## Test plan
- Reset release, PC=0x00000000, memory ready immediately, data 0x00500093 one cycle later, decoder ready. Expected: request at 0x0, instructionOut=0x00500093, instructionPc=0x0, PC written 0x4; next request at 0x4 in cycle 3.
- Decoder holds instructionReady=0 for 5 cycles. Expected: instructionValid stays 1, outputs stable, no PC write, no new request.
- redirectValid (target 0x100) in WAIT_DATA at PC 0x8, data arrives 2 cycles later. Expected: PC written 0x100, data discarded, no instructionValid; next request at 0x100.
- redirectValid and instructionReady in the same HOLD cycle. Expected: one handshake, PC=redirectTarget, not PC+4.
- PC 0x0000000A. Expected: FAULT with no memReadRequest; fetchFault=1 until reset deasserts and reasserts.
- Memory never returns data. Expected: fetchFault=1 exactly TIMEOUT_CYCLES cycles after WAIT_DATA entry; PC at 0xFFFFFFFC consumed writes 0x00000000.
